// File: rtl/ula_arbitro_pkg.sv
// Shared types and constants for the two-requester ULA arbiter.
package ula_arbitro_pkg;

    localparam int LARGURA_PAD = 32;
    localparam int ALUCTL_W    = 3;

    typedef enum logic [1:0] {
        OCIOSO   = 2'd0,
        EXECUTA  = 2'd1,
        RESPONDE = 2'd2
    } estado_t;

endpackage

// File: rtl/ula_arbitro_if.sv
// Requester and ULA-side signals of the arbiter, bundled into one interface.
interface ula_arbitro_if #(
    parameter int LARGURA = ula_arbitro_pkg::LARGURA_PAD
);
    import ula_arbitro_pkg::*;

    logic                req0, req1;
    logic [LARGURA-1:0]  entrada1_0, entrada2_0, entrada1_1, entrada2_1;
    logic [ALUCTL_W-1:0] ALUControl_0, ALUControl_1;
    logic                ack0, ack1;
    logic [LARGURA-1:0]  resultado;
    logic                zero;
    logic                ocupado;
    logic [LARGURA-1:0]  ula_entrada1, ula_entrada2;
    logic [ALUCTL_W-1:0] ula_ALUControl;
    logic [LARGURA-1:0]  ula_resultado;
    logic                ula_zero;

    // Arbiter side
    modport slave (
        input  req0, req1, entrada1_0, entrada2_0, entrada1_1, entrada2_1,
               ALUControl_0, ALUControl_1, ula_resultado, ula_zero,
        output ack0, ack1, resultado, zero, ocupado,
               ula_entrada1, ula_entrada2, ula_ALUControl
    );

    // Requesters plus the ULA instance
    modport master (
        output req0, req1, entrada1_0, entrada2_0, entrada1_1, entrada2_1,
               ALUControl_0, ALUControl_1, ula_resultado, ula_zero,
        input  ack0, ack1, resultado, zero, ocupado,
               ula_entrada1, ula_entrada2, ula_ALUControl
    );

endinterface

// File: rtl/ula_arbitro_rr_selecao.sv
// Combinational 2-way round-robin pick; prioridade names the favoured requester.
module ula_rr_selecao (
    input  logic req0_i,
    input  logic req1_i,
    input  logic prioridade_i,
    output logic concede_o,
    output logic indice_o
);

    assign concede_o = req0_i | req1_i;
    assign indice_o  = (req0_i & req1_i) ? prioridade_i : req1_i;

endmodule

// File: rtl/ula_arbitro.sv
// Shares one external ULA between two requesters: grant, drive operands,
// wait LATENCIA_ULA edges, capture result and pulse the granted ack.
module ula_arbitro
    import ula_arbitro_pkg::*;
#(
    parameter int LARGURA      = LARGURA_PAD,
    parameter int LATENCIA_ULA = 1
) (
    input logic          clock,
    input logic          reset,
    ula_arbitro_if.slave bus
);

    localparam int CW = (LATENCIA_ULA < 1) ? 1 : $clog2(LATENCIA_ULA + 1);

    estado_t             estado_q, estado_d;
    logic                prioridade_q, prioridade_d;
    logic                indice_q, indice_d;
    logic [CW-1:0]       contador_q, contador_d;
    logic [LARGURA-1:0]  e1_q, e1_d, e2_q, e2_d, res_q, res_d;
    logic [ALUCTL_W-1:0] ctl_q, ctl_d;
    logic                zero_q, zero_d;
    logic [1:0]          ack_q, ack_d;

    logic concede, indice;

    ula_rr_selecao u_sel (
        .req0_i       (bus.req0),
        .req1_i       (bus.req1),
        .prioridade_i (prioridade_q),
        .concede_o    (concede),
        .indice_o     (indice)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            estado_q     <= OCIOSO;
            prioridade_q <= 1'b0;
            indice_q     <= 1'b0;
            contador_q   <= '0;
            e1_q         <= '0;
            e2_q         <= '0;
            ctl_q        <= '0;
            res_q        <= '0;
            zero_q       <= 1'b0;
            ack_q        <= 2'b00;
        end else begin
            estado_q     <= estado_d;
            prioridade_q <= prioridade_d;
            indice_q     <= indice_d;
            contador_q   <= contador_d;
            e1_q         <= e1_d;
            e2_q         <= e2_d;
            ctl_q        <= ctl_d;
            res_q        <= res_d;
            zero_q       <= zero_d;
            ack_q        <= ack_d;
        end
    end

    // ack is only ever high in the single RESPONDE cycle, so it defaults low
    always_comb begin
        estado_d     = estado_q;
        prioridade_d = prioridade_q;
        indice_d     = indice_q;
        contador_d   = contador_q;
        e1_d         = e1_q;
        e2_d         = e2_q;
        ctl_d        = ctl_q;
        res_d        = res_q;
        zero_d       = zero_q;
        ack_d        = 2'b00;
        case (estado_q)
            OCIOSO: begin
                if (concede) begin
                    e1_d         = indice ? bus.entrada1_1   : bus.entrada1_0;
                    e2_d         = indice ? bus.entrada2_1   : bus.entrada2_0;
                    ctl_d        = indice ? bus.ALUControl_1 : bus.ALUControl_0;
                    indice_d     = indice;
                    contador_d   = CW'(LATENCIA_ULA);
                    prioridade_d = ~indice;
                    estado_d     = EXECUTA;
                end
            end
            EXECUTA: begin
                if (contador_q != '0) begin
                    contador_d = contador_q - CW'(1);
                end else begin
                    res_d           = bus.ula_resultado;
                    zero_d          = bus.ula_zero;
                    ack_d[indice_q] = 1'b1;
                    estado_d        = RESPONDE;
                end
            end
            RESPONDE: estado_d = OCIOSO;
            default:  estado_d = OCIOSO;
        endcase
    end

    assign bus.ack0           = ack_q[0];
    assign bus.ack1           = ack_q[1];
    assign bus.resultado      = res_q;
    assign bus.zero           = zero_q;
    assign bus.ocupado        = (estado_q != OCIOSO);
    assign bus.ula_entrada1   = e1_q;
    assign bus.ula_entrada2   = e2_q;
    assign bus.ula_ALUControl = ctl_q;

endmodule

// File: tb/tb_ula_arbitro.sv
// Bench for ula_arbitro: instance g runs with LATENCIA_ULA=g against an adder
// stub; a timing-level model is compared every cycle, plus directed literals.
module tb_ula_arbitro;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        rst_s [2];
    logic        req0_s[2], req1_s[2];
    logic [31:0] a0_s[2], b0_s[2], a1_s[2], b1_s[2];
    logic [2:0]  c0_s[2], c1_s[2];

    logic        ack0_w[2], ack1_w[2], ocup_w[2], zero_w[2];
    logic [31:0] res_w[2], ue1_w[2], ue2_w[2];
    logic [2:0]  uc_w[2];

    ula_arbitro_if #(.LARGURA(32)) bus [2] ();

    for (genvar g = 0; g < 2; g++) begin : g_inst
        logic [31:0] soma;
        logic [31:0] stub_q = '0;

        assign bus[g].req0         = req0_s[g];
        assign bus[g].req1         = req1_s[g];
        assign bus[g].entrada1_0   = a0_s[g];
        assign bus[g].entrada2_0   = b0_s[g];
        assign bus[g].entrada1_1   = a1_s[g];
        assign bus[g].entrada2_1   = b1_s[g];
        assign bus[g].ALUControl_0 = c0_s[g];
        assign bus[g].ALUControl_1 = c1_s[g];

        assign soma = bus[g].ula_entrada1 + bus[g].ula_entrada2;
        if (g == 0) begin : g_comb
            assign bus[g].ula_resultado = soma;
        end else begin : g_reg
            always @(posedge clock) stub_q <= soma;
            assign bus[g].ula_resultado = stub_q;
        end
        assign bus[g].ula_zero = (bus[g].ula_resultado == 32'd0);

        assign ack0_w[g] = bus[g].ack0;
        assign ack1_w[g] = bus[g].ack1;
        assign ocup_w[g] = bus[g].ocupado;
        assign zero_w[g] = bus[g].zero;
        assign res_w[g]  = bus[g].resultado;
        assign ue1_w[g]  = bus[g].ula_entrada1;
        assign ue2_w[g]  = bus[g].ula_entrada2;
        assign uc_w[g]   = bus[g].ula_ALUControl;

        ula_arbitro #(.LARGURA(32), .LATENCIA_ULA(g)) dut (
            .clock (clock),
            .reset (rst_s[g]),
            .bus   (bus[g])
        );
    end

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    // Model: an operation granted at some edge produces its ack LAT+1 edges
    // later, the unit is idle again one edge after that.
    bit          m_busy[2], m_who[2], m_prio[2], m_ack0[2], m_ack1[2], m_zero[2];
    int          m_t[2];
    logic [31:0] m_e1[2], m_e2[2], m_res[2];
    logic [2:0]  m_c[2];

    task automatic model_step(input int i);
        bit who;
        if (!rst_s[i]) begin
            m_busy[i] = 0; m_t[i] = 0; m_prio[i] = 0; m_who[i] = 0;
            m_ack0[i] = 0; m_ack1[i] = 0; m_zero[i] = 0;
            m_res[i] = '0; m_e1[i] = '0; m_e2[i] = '0; m_c[i] = '0;
        end else if (!m_busy[i]) begin
            if (req0_s[i] || req1_s[i]) begin
                who = (req0_s[i] && req1_s[i]) ? m_prio[i] : req1_s[i];
                m_e1[i] = who ? a1_s[i] : a0_s[i];
                m_e2[i] = who ? b1_s[i] : b0_s[i];
                m_c[i]  = who ? c1_s[i] : c0_s[i];
                m_who[i] = who; m_prio[i] = !who;
                m_busy[i] = 1; m_t[i] = 0;
            end
        end else begin
            m_t[i]++;
            if (m_t[i] == i + 1) begin
                m_res[i]  = m_e1[i] + m_e2[i];
                m_zero[i] = (m_res[i] == 32'd0);
                if (m_who[i]) m_ack1[i] = 1; else m_ack0[i] = 1;
            end else if (m_t[i] == i + 2) begin
                m_ack0[i] = 0; m_ack1[i] = 0; m_busy[i] = 0;
            end
        end
    endtask

    initial forever begin
        @(posedge clock);
        cyc++;
        model_step(0);
        model_step(1);
    end

    initial forever begin
        @(negedge clock);
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("m%0d_ack0", i), ack0_w[i], m_ack0[i]);
                chk($sformatf("m%0d_ack1", i), ack1_w[i], m_ack1[i]);
                chk($sformatf("m%0d_ocup", i), ocup_w[i], m_busy[i]);
                chk($sformatf("m%0d_res", i),  res_w[i],  m_res[i]);
                chk($sformatf("m%0d_zero", i), zero_w[i], m_zero[i]);
                chk($sformatf("m%0d_ue1", i),  ue1_w[i],  m_e1[i]);
                chk($sformatf("m%0d_ue2", i),  ue2_w[i],  m_e2[i]);
                chk($sformatf("m%0d_uc", i),   uc_w[i],   m_c[i]);
            end
        end
    end

    task automatic wait_ack(input int i, output int who);
        who = -1;
        for (int n = 0; n < 30 && who < 0; n++) begin
            @(negedge clock);
            if (ack0_w[i]) who = 0;
            else if (ack1_w[i]) who = 1;
        end
        if (who < 0) begin
            total++; bad++;
            $display("FAIL ack_timeout inst=%0d got=none exp=ack", i);
        end
    endtask

    int who, c1, c2;

    initial begin
        for (int i = 0; i < 2; i++) begin
            rst_s[i] = 0; req0_s[i] = 0; req1_s[i] = 0;
            a0_s[i] = 0; b0_s[i] = 0; a1_s[i] = 0; b1_s[i] = 0;
            c0_s[i] = 0; c1_s[i] = 0;
        end
        repeat (2) @(negedge clock);
        rst_s[0] = 1; rst_s[1] = 1;
        chk_en = 1;
        chk("rst_res", res_w[1], 0);
        chk("rst_ocup", ocup_w[1], 0);
        chk("rst_ue1", ue1_w[0], 0);

        // 1: single request, latency 1
        req0_s[1] = 1; a0_s[1] = 3; b0_s[1] = 1; c0_s[1] = 3'b011;
        @(negedge clock);
        chk("t1_ue1", ue1_w[1], 3);
        chk("t1_uc", uc_w[1], 3'b011);
        chk("t1_ocup", ocup_w[1], 1);
        @(negedge clock);
        chk("t1_ack_early", ack0_w[1], 0);
        @(negedge clock);
        chk("t1_ack0", ack0_w[1], 1);
        chk("t1_res", res_w[1], 4);
        chk("t1_zero", zero_w[1], 0);
        chk("t1_ack1", ack1_w[1], 0);
        req0_s[1] = 0;
        @(negedge clock);
        chk("t1_ack_drop", ack0_w[1], 0);
        chk("t1_idle", ocup_w[1], 0);

        // 2: contention after reset, both held -> 0,1,0,1
        rst_s[1] = 0; @(negedge clock); rst_s[1] = 1;
        a0_s[1] = 10; b0_s[1] = 1; a1_s[1] = 20; b1_s[1] = 2; c1_s[1] = 3'b010;
        req0_s[1] = 1; req1_s[1] = 1;
        for (int k = 0; k < 4; k++) begin
            wait_ack(1, who);
            chk($sformatf("t2_order%0d", k), who, k % 2);
            chk($sformatf("t2_res%0d", k), res_w[1], (k % 2) ? 22 : 11);
        end
        req0_s[1] = 0; req1_s[1] = 0;
        @(negedge clock);

        // 3: zero flag from requester 1
        req1_s[1] = 1; a1_s[1] = 5; b1_s[1] = 32'hFFFF_FFFB;
        wait_ack(1, who);
        chk("t3_who", who, 1);
        chk("t3_res", res_w[1], 0);
        chk("t3_zero", zero_w[1], 1);
        req1_s[1] = 0;
        @(negedge clock);
        chk("t3_ack_1cyc", ack1_w[1], 0);

        // 4: operand change after grant does not disturb operation
        @(negedge clock);
        req0_s[1] = 1; a0_s[1] = 3; b0_s[1] = 1;
        @(negedge clock);
        a0_s[1] = 7;
        wait_ack(1, who);
        chk("t4_res", res_w[1], 4);
        req0_s[1] = 0;
        @(negedge clock);

        // 5: reset during EXECUTA aborts the operation
        @(negedge clock);
        req0_s[1] = 1; a0_s[1] = 9; b0_s[1] = 9;
        @(negedge clock);
        chk("t5_busy", ocup_w[1], 1);
        rst_s[1] = 0; req0_s[1] = 0;
        @(negedge clock);
        chk("t5_ocup", ocup_w[1], 0);
        chk("t5_res", res_w[1], 0);
        chk("t5_ack", ack0_w[1], 0);
        rst_s[1] = 1;
        repeat (3) begin
            @(negedge clock);
            chk("t5_no_ack", ack0_w[1], 0);
        end
        req0_s[1] = 1; a0_s[1] = 10; b0_s[1] = 20;
        wait_ack(1, who);
        chk("t5_who", who, 0);
        chk("t5_fresh", res_w[1], 30);
        req0_s[1] = 0;
        @(negedge clock);

        // 6: latency 0, back-to-back spacing
        req0_s[0] = 1; a0_s[0] = 2; b0_s[0] = 2; c0_s[0] = 3'b010;
        @(negedge clock);
        chk("t6_ack_early", ack0_w[0], 0);
        chk("t6_ocup", ocup_w[0], 1);
        @(negedge clock);
        chk("t6_ack0", ack0_w[0], 1);
        chk("t6_res", res_w[0], 4);
        c1 = cyc;
        a0_s[0] = 6;
        wait_ack(0, who);
        c2 = cyc;
        chk("t6_res2", res_w[0], 8);
        chk("t6_spacing", c2 - c1, 3);
        req0_s[0] = 0;

        repeat (3) @(negedge clock);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ula_arbitro.md
Name: ula_arbitro

Overview:
- Round-robin arbiter and sequencer that shares one ULA (32-bit ALU, 3-bit ALUControl, zero flag) between two requesters.
- For each request it accepts the operands, drives the ULA inputs, waits the ULA latency, then returns resultado/zero with a one-cycle ack.
- Sits between the ULA instance and the datapath units that need arithmetic, e.g. the main execute path and the address/branch path.

Parameters:
- LARGURA, 32, operand/result width.
- LATENCIA_ULA, 1, clock edges from ULA input change to valid ULA output (0 = combinational ULA).

Ports:
- clock  in  1  single system clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset (sampled on the clock rising edge; 0 = reset).
- req0  in  1  requester 0 request; held high until ack0.
- entrada1_0, entrada2_0  in  LARGURA  requester 0 operands; stable while req0 is high.
- ALUControl_0  in  3  requester 0 operation.
- ack0  out  1  one-cycle pulse; resultado/zero are valid for requester 0.
- req1, entrada1_1, entrada2_1, ALUControl_1, ack1  same as above, for requester 1.
- resultado  out  LARGURA  registered result of the last completed operation.
- zero  out  1  registered ULA zero flag of the last completed operation.
- ocupado  out  1  high whenever the state is not OCIOSO.
- ula_entrada1, ula_entrada2  out  LARGURA  registered ULA operand drive.
- ula_ALUControl  out  3  registered ULA operation drive.
- ula_resultado  in  LARGURA  ULA result.
- ula_zero  in  1  ULA zero flag.

Behaviour:
- Reset (reset=0 at an edge):
  - State OCIOSO, prioridade=0.
  - All outputs and internal registers 0: ack0/1, resultado, zero, ocupado, ula_*.
  - Reset mid-operation aborts it; no ack is issued.
- FSM states: OCIOSO, EXECUTA, RESPONDE.
- OCIOSO, edge k, any req high:
  - Grant one requester: the only one requesting, or the one selected by prioridade when both request.
  - Load the granted operands and op into ula_entrada1/2 and ula_ALUControl; record the granted index.
  - Load contador=LATENCIA_ULA; toggle prioridade to the other requester; go to EXECUTA.
  - No req: stay in OCIOSO; all registers hold.
- EXECUTA, each edge:
  - contador≠0: decrement.
  - contador==0: capture ula_resultado→resultado and ula_zero→zero, set ack of the granted requester, go to RESPONDE.
- RESPONDE: lasts exactly one cycle. Next edge clears ack and returns to OCIOSO.
- Timing:
  - ack is high in the cycle after edge k+1+LATENCIA_ULA.
  - Turnaround is LATENCIA_ULA+3 cycles per operation; no pipelining.
- ula_* outputs hold their last values outside EXECUTA.
- resultado/zero hold until the next capture.
- ack0 and ack1 are never high simultaneously.
- A requester drops req after seeing ack. If req is still high in OCIOSO, it is treated as a new request. Under contention, round-robin guarantees alternation.
- req dropped mid-operation: the operation completes and ack is still pulsed; the requester ignores it.
- Operands are latched at the grant edge, so later changes to the requester's inputs do not affect the operation in flight.
- No arithmetic is performed here; widths pass through unchanged.

Decomposition:
- Shared package:
  - State encoding constants OCIOSO=2'd0, EXECUTA=2'd1, RESPONDE=2'd2.
  - LARGURA default.
  - ALUControl width constant (3).
- One natural sub-module: ula_rr_selecao.
  - Combinational 2-way round-robin pick.
  - Inputs: req0, req1, prioridade. Outputs: concede, indice.
- Top-level integration instantiates ula_arbitro beside the ULA; the ULA is not instantiated inside the arbiter.

Test Plan:
- Bench uses a ULA stub with LATENCIA_ULA delay: result=entrada1+entrada2, zero=(result==0). Run with LATENCIA_ULA=1 and LATENCIA_ULA=0.
1. Single request, LATENCIA_ULA=1: req0=1, entrada1_0=3, entrada2_0=1, ALUControl_0=3'b011 at edge k -> ula_entrada1=3 after k; ack0=1 and resultado=4, zero=0 in the cycle after edge k+2; ack1 never set.
2. Both requesting at once after reset: req0=req1=1 -> requester 0 acked first, then requester 1; with both held high, grants alternate 0,1,0,1.
3. Zero flag: req1 with entrada1_1=5, entrada2_1=32'hFFFFFFFB -> resultado=0, zero=1, ack1 pulse exactly one cycle.
4. Operand change after grant: alter entrada1_0 from 3 to 7 one cycle after grant -> resultado still 4.
5. Reset mid-operation: reset=0 during EXECUTA -> no ack, ocupado=0, resultado=0 next cycle; a fresh request after reset completes normally.
6. LATENCIA_ULA=0: req0 at edge k -> ack0 in the cycle after edge k+1; back-to-back requests are spaced 3 cycles apart.
